// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX byte stream between NREQ requesters.
// A grant is held for a whole packet (or MAX_BURST beats), then released once the TX core goes idle.
module uart_tx_arbiter #(
  parameter int NREQ      = 2,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               enable,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic               tx_valid,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_ready,
  input  logic               tx_busy,
  output logic [NREQ-1:0]    grant,
  output logic               arb_active
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]      state;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   beat_cnt;

  logic            found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   nxt_ptr;
  logic [NREQ-1:0] win_onehot;
  int              cand;
  logic            beat;
  logic            last_g;
  logic            burst_end;

  // Rotating priority search starting at rr_ptr
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_valid[IW'(cand)]) begin
        found   = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  assign nxt_ptr    = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

  // Granted requester is passed straight through to the TX core while in XFER
  always_comb begin
    req_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    if (state == ST_XFER) begin
      tx_valid          = req_valid[gidx_q];
      req_ready[gidx_q] = tx_ready;
      if (req_valid[gidx_q]) tx_data = req_data[int'(gidx_q)*DW +: DW];
    end
  end

  assign beat       = (state == ST_XFER) && tx_valid && tx_ready;
  assign last_g     = req_last[gidx_q];
  assign burst_end  = (beat_cnt == CW'(MAX_BURST - 1));
  assign grant      = grant_q;
  assign arb_active = (state != ST_IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && found) begin
            state    <= ST_XFER;
            grant_q  <= win_onehot;
            gidx_q   <= win_idx;
            rr_ptr   <= nxt_ptr;
            beat_cnt <= '0;
          end
        end
        ST_XFER: begin
          if (beat) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (last_g || burst_end) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Wait for the frame on the wire to finish before anyone else may start
          if (!tx_busy) begin
            state   <= ST_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a transaction-level model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 2;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic               clk = 1'b0;
  logic               wb_rst_n;
  logic               enable;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               tx_valid;
  logic [DW-1:0]      tx_data;
  logic               tx_ready;
  logic               tx_busy;
  logic [NREQ-1:0]    grant;
  logic               arb_active;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
    .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .grant(grant), .arb_active(arb_active)
  );

  int errors = 0;
  int checks = 0;

  // Per-requester pending bytes {last, data}; vmask gates whether a requester presents its byte
  logic [DW:0]     q [NREQ][$];
  logic [NREQ-1:0] vmask;

  // Model: phase 0 = no owner, 1 = owner passing bytes, 2 = owner waiting for line idle
  int m_phase, m_owner, m_ptr, m_beats;
  logic m_e_txv;

  // Captured DUT outputs of the last checked cycle
  logic [NREQ-1:0] a_grant, a_rdy;
  logic            a_txv, a_act;
  logic [DW-1:0]   a_txd;

  // Observed byte stream and literal expectation
  int log_src[$], log_dat[$], exp_src[$], exp_dat[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic ex(int s, int d);
    exp_src.push_back(s);
    exp_dat.push_back(d);
  endtask

  task automatic check_log(string nm);
    chk({nm, "_len"}, log_src.size(), exp_src.size());
    for (int k = 0; k < exp_src.size() && k < log_src.size(); k++) begin
      chk({nm, "_src"}, log_src[k], exp_src[k]);
      chk({nm, "_dat"}, log_dat[k], exp_dat[k]);
    end
    log_src.delete(); log_dat.delete(); exp_src.delete(); exp_dat.delete();
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = -1; m_ptr = 0; m_beats = 0;
  endtask

  task automatic drive();
    logic [DW:0] ent;
    for (int i = 0; i < NREQ; i++) begin
      if (q[i].size() > 0 && vmask[i]) begin
        ent = q[i][0];
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = ent[DW-1:0];
        req_last[i] = ent[DW];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = DW'($urandom);
        req_last[i] = 1'(($urandom));
      end
    end
  endtask

  task automatic model_step();
    logic [DW:0] ent;
    case (m_phase)
      0: if (enable && (req_valid != 0)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (m_phase == 0 && req_valid[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            m_ptr   = (m_owner + 1) % NREQ;
            m_beats = 0;
            m_phase = 1;
          end
        end
      end
      1: if (m_e_txv && tx_ready) begin
        ent = q[m_owner].pop_front();
        m_beats++;
        if (ent[DW] || m_beats == MB) m_phase = 2;
      end
      default: if (!tx_busy) begin
        m_phase = 0;
        m_owner = -1;
      end
    endcase
  endtask

  task automatic cycle();
    logic [NREQ-1:0] e_grant, e_rdy;
    logic [DW-1:0]   e_txd;
    drive();
    @(negedge clk);
    if (!wb_rst_n) model_reset();
    e_grant = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
    m_e_txv = (m_phase == 1) && req_valid[m_owner];
    e_txd   = m_e_txv ? req_data[m_owner*DW +: DW] : '0;
    e_rdy   = (m_phase == 1) ? NREQ'(tx_ready) << m_owner : '0;
    chk("grant", grant, e_grant);
    chk("arb_active", arb_active, m_phase != 0);
    chk("tx_valid", tx_valid, m_e_txv);
    chk("tx_data", tx_data, e_txd);
    chk("req_ready", req_ready, e_rdy);
    a_grant = grant; a_rdy = req_ready; a_txv = tx_valid; a_act = arb_active; a_txd = tx_data;
    if (tx_valid && tx_ready) begin
      for (int i = 0; i < NREQ; i++) if (grant[i]) log_src.push_back(i);
      log_dat.push_back(int'(tx_data));
    end
    @(posedge clk);
    if (wb_rst_n) model_step(); else model_reset();
    #1;
  endtask

  task automatic do_reset();
    wb_rst_n = 1'b0;
    cycle();
    wb_rst_n = 1'b1;
  endtask

  initial begin
    logic [DW:0] ent;
    int len;
    wb_rst_n = 1'b0; enable = 1'b0; tx_ready = 1'b0; tx_busy = 1'b0; vmask = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    model_reset();
    #2;
    repeat (2) cycle();
    chk("rst_grant", a_grant, 0);
    chk("rst_txv", a_txv, 0);
    chk("rst_rdy", a_rdy, 0);
    wb_rst_n = 1'b1;

    // Single 3-byte packet from requester 0
    enable = 1'b1; tx_ready = 1'b1; tx_busy = 1'b1;
    q[0].push_back({1'b0, 8'h41}); q[0].push_back({1'b0, 8'h42}); q[0].push_back({1'b1, 8'h43});
    vmask = 2'b01;
    cycle(); chk("t1_nogrant_yet", a_grant, 0);
    cycle(); chk("t1_grant", a_grant, 2'b01); chk("t1_d0", a_txd, 8'h41);
    cycle(); chk("t1_d1", a_txd, 8'h42);
    cycle(); chk("t1_d2", a_txd, 8'h43);
    cycle(); chk("t1_drain_act", a_act, 1); chk("t1_drain_txv", a_txv, 0); chk("t1_drain_grant", a_grant, 2'b01);
    repeat (2) cycle();
    chk("t1_drain_hold", a_act, 1);
    tx_busy = 1'b0;
    cycle(); cycle();
    chk("t1_idle_act", a_act, 0); chk("t1_idle_grant", a_grant, 0);
    ex(0, 'h41); ex(0, 'h42); ex(0, 'h43);
    check_log("t1_log");

    // Simultaneous 1-byte packets, two rounds
    do_reset();
    vmask = 2'b11;
    for (int r = 0; r < 2; r++) begin
      q[0].push_back({1'b1, 8'hA0 + 8'(r)}); q[1].push_back({1'b1, 8'hB0 + 8'(r)});
      repeat (8) cycle();
      ex(0, 'hA0 + r); ex(1, 'hB0 + r);
    end
    check_log("t2_log");

    // Burst rotation (MAX_BURST=4), then async reset mid-XFER
    do_reset();
    for (int b = 0; b < 10; b++) q[0].push_back({1'b0, 8'(b)});
    q[1].push_back({1'b0, 8'h10}); q[1].push_back({1'b1, 8'h11});
    repeat (30) cycle();
    for (int b = 0; b < 4; b++) ex(0, b);
    ex(1, 'h10); ex(1, 'h11);
    for (int b = 4; b < 10; b++) ex(0, b);
    check_log("t3_log");
    chk("t3_hold_grant", a_grant, 2'b01); chk("t3_hold_act", a_act, 1);
    q[0].push_back({1'b0, 8'h50}); q[0].push_back({1'b1, 8'h51}); q[1].push_back({1'b1, 8'h60});
    tx_ready = 1'b0;
    repeat (2) cycle();
    chk("t5_pre_txv", a_txv, 1);
    wb_rst_n = 1'b0;
    #1;
    chk("t5_async_grant", grant, 0); chk("t5_async_txv", tx_valid, 0);
    chk("t5_async_rdy", req_ready, 0); chk("t5_async_act", arb_active, 0);
    model_reset();
    cycle();
    wb_rst_n = 1'b1; tx_ready = 1'b1;
    repeat (12) cycle();
    ex(0, 'h50); ex(0, 'h51); ex(1, 'h60);
    check_log("t5_log");

    // Stall with tx_ready low mid-packet
    do_reset();
    tx_busy = 1'b1; vmask = 2'b01;
    for (int b = 0; b < 5; b++) q[0].push_back({1'b0, 8'h70 + 8'(b)});
    cycle(); cycle();
    tx_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("t4_stall_txd", a_txd, 8'h71); chk("t4_stall_rdy", a_rdy, 0); chk("t4_stall_txv", a_txv, 1);
    end
    tx_ready = 1'b1;
    q[0].push_back({1'b1, 8'h75});
    repeat (4) cycle();
    tx_busy = 1'b0;
    repeat (8) cycle();
    for (int b = 0; b < 6; b++) ex(0, 'h70 + b);
    check_log("t4_log");

    // enable dropped mid-packet
    do_reset();
    vmask = 2'b10;
    q[1].push_back({1'b0, 8'h80}); q[1].push_back({1'b0, 8'h81});
    q[1].push_back({1'b0, 8'h82}); q[1].push_back({1'b1, 8'h83});
    cycle(); cycle();
    enable = 1'b0;
    q[0].push_back({1'b1, 8'h90}); vmask = 2'b11;
    repeat (6) cycle();
    repeat (3) begin
      cycle(); chk("t6_nogrant", a_grant, 0); chk("t6_noact", a_act, 0);
    end
    enable = 1'b1;
    cycle(); chk("t6_grant_lat0", a_grant, 0);
    cycle(); chk("t6_grant_req0", a_grant, 2'b01);
    repeat (4) cycle();
    ex(1, 'h80); ex(1, 'h81); ex(1, 'h82); ex(1, 'h83); ex(0, 'h90);
    check_log("t6_log");

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (q[i].size() < 8 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) begin
            ent = {(b == len - 1) ? 1'b1 : 1'b0, DW'($urandom)};
            q[i].push_back(ent);
          end
        end
        vmask[i] = ($urandom_range(0, 4) != 0);
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      tx_busy  = ($urandom_range(0, 1) != 0);
      enable   = ($urandom_range(0, 9) != 0);
      cycle();
      log_src.delete(); log_dat.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
